// File: rtl/alu_scheduler_if.sv
// Bundle of request, response and shared-ALU signals for alu_scheduler.
// The master side is the requesters plus the external combinational ALU; the slave side is the scheduler.
interface alu_scheduler_if;
  logic       req_valid0;
  logic       req_valid1;
  logic [2:0] req_s0;
  logic [2:0] req_s1;
  logic [3:0] req_a0;
  logic [3:0] req_b0;
  logic [3:0] req_a1;
  logic [3:0] req_b1;
  logic       req_ready0;
  logic       req_ready1;
  logic       rsp_valid0;
  logic       rsp_valid1;
  logic       rsp_ready0;
  logic       rsp_ready1;
  logic [7:0] rsp_data;
  logic [2:0] alu_s;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [7:0] alu_out;
  logic       busy;
  logic [7:0] ops_done;

  modport master (
    output req_valid0, req_valid1, req_s0, req_s1,
    output req_a0, req_b0, req_a1, req_b1,
    output rsp_ready0, rsp_ready1, alu_out,
    input  req_ready0, req_ready1, rsp_valid0, rsp_valid1,
    input  rsp_data, alu_s, alu_a, alu_b, busy, ops_done
  );

  modport slave (
    input  req_valid0, req_valid1, req_s0, req_s1,
    input  req_a0, req_b0, req_a1, req_b1,
    input  rsp_ready0, rsp_ready1, alu_out,
    output req_ready0, req_ready1, rsp_valid0, rsp_valid1,
    output rsp_data, alu_s, alu_a, alu_b, busy, ops_done
  );
endinterface

// File: rtl/alu_scheduler.sv
// Two-requester round-robin scheduler for one shared combinational ALU.
// One operation is in flight at a time: IDLE grants, EXEC waits ALU_LAT cycles, RESP holds the result.
module alu_scheduler #(
  parameter int ALU_LAT = 1
) (
  input logic            clk,
  input logic            rst,
  alu_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  // ALU_LAT is meaningful in 1..4, so the countdown fits in two bits.
  localparam logic [1:0] LAT_LOAD = 2'(ALU_LAT - 1);

  state_t     state_q, state_d;
  logic       prio_q, prio_d;
  logic       owner_q, owner_d;
  logic [2:0] op_s_q, op_s_d;
  logic [3:0] op_a_q, op_a_d;
  logic [3:0] op_b_q, op_b_d;
  logic [1:0] lat_q, lat_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic [7:0] ops_done_q, ops_done_d;
  logic       grant1;

  // Requester 1 wins when it is alone or when both are valid and it holds priority.
  assign grant1 = bus.req_valid1 && (!bus.req_valid0 || prio_q);

  always_comb begin
    state_d        = state_q;
    prio_d         = prio_q;
    owner_d        = owner_q;
    op_s_d         = op_s_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    lat_d          = lat_q;
    rsp_data_d     = rsp_data_q;
    ops_done_d     = ops_done_q;
    bus.req_ready0 = 1'b0;
    bus.req_ready1 = 1'b0;
    bus.rsp_valid0 = 1'b0;
    bus.rsp_valid1 = 1'b0;
    bus.alu_s      = 3'd0;
    bus.alu_a      = 4'd0;
    bus.alu_b      = 4'd0;

    case (state_q)
      IDLE: begin
        bus.req_ready0 = bus.req_valid0 && !grant1;
        bus.req_ready1 = grant1;
        if (bus.req_valid0 || bus.req_valid1) begin
          owner_d = grant1;
          prio_d  = !grant1;
          op_s_d  = grant1 ? bus.req_s1 : bus.req_s0;
          op_a_d  = grant1 ? bus.req_a1 : bus.req_a0;
          op_b_d  = grant1 ? bus.req_b1 : bus.req_b0;
          lat_d   = LAT_LOAD;
          state_d = EXEC;
        end
      end

      EXEC: begin
        bus.alu_s = op_s_q;
        bus.alu_a = op_a_q;
        bus.alu_b = op_b_q;
        if (lat_q == 2'd0) begin
          rsp_data_d = bus.alu_out;
          state_d    = RESP;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end

      RESP: begin
        bus.rsp_valid0 = !owner_q;
        bus.rsp_valid1 = owner_q;
        // Only the owner's ready can close the response.
        if (owner_q ? bus.rsp_ready1 : bus.rsp_ready0) begin
          ops_done_d = ops_done_q + 8'd1;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      owner_q    <= 1'b0;
      op_s_q     <= 3'd0;
      op_a_q     <= 4'd0;
      op_b_q     <= 4'd0;
      lat_q      <= 2'd0;
      rsp_data_q <= 8'd0;
      ops_done_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      owner_q    <= owner_d;
      op_s_q     <= op_s_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      lat_q      <= lat_d;
      rsp_data_q <= rsp_data_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.rsp_data = rsp_data_q;
  assign bus.ops_done = ops_done_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler: an ALU_LAT=1 instance carries most scenarios, an ALU_LAT=4 instance the long-latency case.
// Expected results are queued when requests are driven and popped when a response appears.
module tb_alu_scheduler;

  logic clk;
  logic rst;

  alu_scheduler_if bus1 ();
  alu_scheduler_if bus4 ();

  alu_scheduler #(.ALU_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  alu_scheduler #(.ALU_LAT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  typedef struct packed {
    logic       owner;
    logic [2:0] s;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  bit         model_prio;
  logic [7:0] model_ops;
  int         n_pass   = 0;
  int         n_checks = 0;

  // Reference behaviour of the external ALU; the same function drives alu_out.
  function automatic logic [7:0] alu_model(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      3'd0:    return {4'd0, a} + {4'd0, b};
      3'd1:    return {4'd0, a} - {4'd0, b};
      3'd2:    return {4'd0, a} * {4'd0, b};
      3'd3:    return {4'd0, a & b};
      3'd4:    return {4'd0, a | b};
      3'd5:    return {4'd0, a ^ b};
      3'd6:    return {a, b};
      default: return {b, a};
    endcase
  endfunction

  assign bus1.alu_out = alu_model(bus1.alu_s, bus1.alu_a, bus1.alu_b);
  assign bus4.alu_out = alu_model(bus4.alu_s, bus4.alu_a, bus4.alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t make_exp(input bit k, input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    e.owner = k;
    e.s     = s;
    e.a     = a;
    e.b     = b;
    e.data  = alu_model(s, a, b);
    return e;
  endfunction

  task automatic drive_req(input bit k, input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    if (k) begin
      bus1.req_valid1 = 1'b1;
      bus1.req_s1     = s;
      bus1.req_a1     = a;
      bus1.req_b1     = b;
    end else begin
      bus1.req_valid0 = 1'b1;
      bus1.req_s0     = s;
      bus1.req_a0     = a;
      bus1.req_b0     = b;
    end
  endtask

  task automatic apply_stimulus(input bit k, input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    sb.push_back(make_exp(k, s, a, b));
    model_prio = !k;
    drive_req(k, s, a, b);
    #1;
  endtask

  // Both requesters at once: the priority holder goes first, and the pointer ends where it started.
  task automatic apply_pair(input logic [2:0] s0, input logic [3:0] a0, input logic [3:0] b0,
                            input logic [2:0] s1, input logic [3:0] a1, input logic [3:0] b1);
    if (model_prio) begin
      sb.push_back(make_exp(1'b1, s1, a1, b1));
      sb.push_back(make_exp(1'b0, s0, a0, b0));
    end else begin
      sb.push_back(make_exp(1'b0, s0, a0, b0));
      sb.push_back(make_exp(1'b1, s1, a1, b1));
    end
    drive_req(1'b0, s0, a0, b0);
    drive_req(1'b1, s1, a1, b1);
    #1;
  endtask

  task automatic accept_and_wait(input int exp_lat, output logic [7:0] got);
    exp_t e;
    bit   found;
    bit   granted1;
    int   cyc;
    got = 8'd0;
    if (sb.size() == 0) begin
      $display("[TB] FAIL sb_empty observed=0 expected=pending entry");
      $fatal(1, "[TB] scoreboard underflow");
    end
    e     = sb[0];
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus1.req_ready0 || bus1.req_ready1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check_output("accept_seen", 32'(found), 32'd1);
    if (!found) return;
    check_output("grant", {30'd0, bus1.req_ready1, bus1.req_ready0}, e.owner ? 32'd2 : 32'd1);
    granted1 = bus1.req_ready1;
    @(posedge clk);
    #1;
    if (granted1) bus1.req_valid1 = 1'b0;
    else          bus1.req_valid0 = 1'b0;
    @(negedge clk);
    check_output("exec_alu", {21'd0, bus1.alu_s, bus1.alu_a, bus1.alu_b}, {21'd0, e.s, e.a, e.b});
    check_output("exec_ready", {30'd0, bus1.req_ready1, bus1.req_ready0}, 32'd0);
    cyc   = 1;
    found = 1'b0;
    while (cyc < 12) begin
      if (bus1.rsp_valid0 || bus1.rsp_valid1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check_output("rsp_seen", 32'(found), 32'd1);
    if (!found) return;
    e = sb.pop_front();
    check_output("rsp_latency", 32'(cyc), 32'(exp_lat));
    check_output("rsp_owner", {30'd0, bus1.rsp_valid1, bus1.rsp_valid0}, e.owner ? 32'd2 : 32'd1);
    check_output("rsp_data", {24'd0, bus1.rsp_data}, {24'd0, e.data});
    got = e.data;
  endtask

  task automatic finish_handshake();
    @(posedge clk);
    model_ops = model_ops + 8'd1;
    @(negedge clk);
    #1;
    check_output("ops_done", {24'd0, bus1.ops_done}, {24'd0, model_ops});
    check_output("rsp_cleared", {30'd0, bus1.rsp_valid1, bus1.rsp_valid0}, 32'd0);
  endtask

  task automatic serve(input int exp_lat);
    logic [7:0] d;
    accept_and_wait(exp_lat, d);
    finish_handshake();
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus1.req_valid0 = 1'b0;
    bus1.req_valid1 = 1'b0;
    bus4.req_valid0 = 1'b0;
    bus4.req_valid1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    model_ops  = 8'd0;
    model_prio = 1'b0;
    sb.delete();
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_busy"},     32'(bus1.busy), 32'd0);
    check_output({tag, "_rsp_valid"}, {30'd0, bus1.rsp_valid1, bus1.rsp_valid0}, 32'd0);
    check_output({tag, "_req_ready"}, {30'd0, bus1.req_ready1, bus1.req_ready0}, 32'd0);
    check_output({tag, "_alu"},      {21'd0, bus1.alu_s, bus1.alu_a, bus1.alu_b}, 32'd0);
    check_output({tag, "_rsp_data"}, {24'd0, bus1.rsp_data}, 32'd0);
    check_output({tag, "_ops_done"}, {24'd0, bus1.ops_done}, 32'd0);
  endtask

  initial begin
    logic [7:0] held;
    rst = 1'b1;
    {bus1.req_valid0, bus1.req_valid1, bus1.req_s0, bus1.req_s1} = '0;
    {bus1.req_a0, bus1.req_b0, bus1.req_a1, bus1.req_b1}         = '0;
    {bus4.req_valid0, bus4.req_valid1, bus4.req_s0, bus4.req_s1} = '0;
    {bus4.req_a0, bus4.req_b0, bus4.req_a1, bus4.req_b1}         = '0;
    bus1.rsp_ready0 = 1'b1;
    bus1.rsp_ready1 = 1'b1;
    bus4.rsp_ready0 = 1'b1;
    bus4.rsp_ready1 = 1'b1;
    model_ops  = 8'd0;
    model_prio = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    $display("[TB] reset state");
    check_reset_outputs("reset");
    check_output("reset_lat4_busy", 32'(bus4.busy), 32'd0);

    $display("[TB] contention from reset");
    apply_pair(3'd0, 4'd1, 4'd2, 3'd6, 4'd3, 4'd4);
    serve(2);
    serve(2);
    apply_pair(3'd2, 4'd5, 4'd6, 3'd5, 4'd7, 4'd8);
    serve(2);
    serve(2);

    $display("[TB] single request");
    do_reset();
    apply_stimulus(1'b0, 3'd1, 4'd2, 4'd7);
    serve(2);

    $display("[TB] response backpressure");
    bus1.rsp_ready1 = 1'b0;
    apply_stimulus(1'b1, 3'd5, 4'hA, 4'h6);
    accept_and_wait(2, held);
    apply_stimulus(1'b0, 3'd3, 4'hC, 4'h5);
    for (int c = 0; c < 5; c++) begin
      check_output("bp_hold", {21'd0, bus1.rsp_valid1, bus1.rsp_valid0, bus1.rsp_data, bus1.busy, bus1.req_ready0},
                   {21'd0, 1'b1, 1'b0, held, 1'b1, 1'b0});
      @(negedge clk);
      #1;
    end
    bus1.rsp_ready1 = 1'b1;
    finish_handshake();
    serve(2);

    $display("[TB] ALU_LAT=4");
    @(negedge clk);
    bus4.req_valid0 = 1'b1;
    bus4.req_s0     = 3'd2;
    bus4.req_a0     = 4'd3;
    bus4.req_b0     = 4'd5;
    #1;
    check_output("lat4_ready", {30'd0, bus4.req_ready1, bus4.req_ready0}, 32'd1);
    @(posedge clk);
    #1;
    bus4.req_valid0 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check_output("lat4_exec", {20'd0, bus4.alu_s, bus4.alu_a, bus4.alu_b, bus4.rsp_valid0},
                   {20'd0, 3'd2, 4'd3, 4'd5, 1'b0});
    end
    @(negedge clk);
    check_output("lat4_rsp_valid", 32'(bus4.rsp_valid0), 32'd1);
    check_output("lat4_rsp_data", {24'd0, bus4.rsp_data}, {24'd0, alu_model(3'd2, 4'd3, 4'd5)});
    @(negedge clk);
    check_output("lat4_ops_done", {24'd0, bus4.ops_done}, 32'd1);
    check_output("lat4_idle", {30'd0, bus4.busy, bus4.rsp_valid0}, 32'd0);

    $display("[TB] reset during response");
    apply_stimulus(1'b1, 3'd4, 4'd9, 4'd3);
    accept_and_wait(2, held);
    rst             = 1'b1;
    bus1.req_valid0 = 1'b0;
    bus1.req_valid1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    model_ops  = 8'd0;
    model_prio = 1'b0;
    #1;
    check_reset_outputs("rst_resp");
    @(negedge clk);
    check_output("rst_resp_later_ops", {24'd0, bus1.ops_done}, 32'd0);

    $display("[TB] 256 back-to-back operations");
    for (int i = 0; i < 256; i++) begin
      apply_stimulus(i[0], 3'(i), 4'(i), 4'(i >> 4));
      serve(2);
    end
    check_output("wrap_ops_done", {24'd0, bus1.ops_done}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check_output("wrap_quiet", {29'd0, bus1.busy, bus1.rsp_valid1, bus1.rsp_valid0}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
